sha256_stream_core: RTL and testbench

- Iterative, handshaked SHA-256 engine, one round per clock; parametrised successor of the fixed unrolled double-hash top.
- Accepts pre-padded 512-bit chunks of arbitrary-length messages, chaining the hash state across chunks.
- Optionally re-hashes the 256-bit digest (double SHA-256), selected per message.
- Sits between the chunk feeder and the result/compare logic.

---
 rtl/sha256_stream_core.sv | 163 ++++++++++++++++
 tb/tb_sha256_stream_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_core.sv
// Iterative SHA-256 core, one round per clock, chaining state across 512-bit chunks with optional double hash.
// Optional digest-vs-target comparator enabled by defining SHA256_TARGET_CMP_EN. CHUNKSIZE must be 512.
module sha256_stream_core #(
   parameter int CHUNKSIZE = 512,
   parameter int TAG_W     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CHUNKSIZE-1:0]   datain,
   input  logic                   in_first,
   input  logic                   in_last,
   input  logic                   in_double,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CHUNKSIZE/2-1:0] final_hout,
   output logic [TAG_W-1:0]       out_tag
`ifdef SHA256_TARGET_CMP_EN
   ,
   input  logic [CHUNKSIZE/2-1:0] target,
   output logic                   hit
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   logic [1:0]       state;
   logic [5:0]       cnt;
   logic             pass, last_q, double_q;
   logic [TAG_W-1:0] tag_q;
   logic [31:0]      w    [0:15];
   logic [31:0]      wk   [0:7];
   logic [31:0]      hreg [0:7];
   logic [31:0]      hsum [0:7];
   logic [31:0]      t1, t2, w_next;
   logic [255:0]     digest_next;

   // NOTE: every signal gets a value on every pass, so this block cannot infer latches.
   always_comb begin
      t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
         + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[cnt] + w[0];
      t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
         + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
      w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
             + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
      for (int i = 0; i < 8; i++) hsum[i] = hreg[i] + wk[i];
      digest_next = {hsum[0], hsum[1], hsum[2], hsum[3], hsum[4], hsum[5], hsum[6], hsum[7]};
   end

   // NOTE: the schedule and working words are plain flops rather than RAM, so they reset with everything else.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         pass     <= 1'b0;
         last_q   <= 1'b0;
         double_q <= 1'b0;
         tag_q    <= '0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
         for (int i = 0; i < 8; i++) begin
            wk[i]   <= '0;
            hreg[i] <= '0;
         end
`ifdef SHA256_TARGET_CMP_EN
         hit <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every register in a round samples the pre-edge values.
         case (state)
            S_IDLE: if (in_valid) begin
               for (int i = 0; i < 16; i++) w[i] <= datain[511-32*i -: 32];
               if (in_first) begin
                  for (int i = 0; i < 8; i++) begin
                     wk[i]   <= IV[i];
                     hreg[i] <= IV[i];
                  end
                  double_q <= in_double;
                  tag_q    <= in_tag;
                  pass     <= 1'b0;
               end else begin
                  for (int i = 0; i < 8; i++) wk[i] <= hreg[i];
               end
               last_q <= in_last;
               cnt    <= '0;
               state  <= S_ROUND;
            end
            S_ROUND: begin
               wk[0] <= t1 + t2;
               wk[1] <= wk[0];
               wk[2] <= wk[1];
               wk[3] <= wk[2];
               wk[4] <= wk[3] + t1;
               wk[5] <= wk[4];
               wk[6] <= wk[5];
               wk[7] <= wk[6];
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_next;
               cnt   <= cnt + 6'd1;
               if (cnt == 6'd63) state <= S_FINAL;
            end
            S_FINAL: begin
               for (int i = 0; i < 8; i++) hreg[i] <= hsum[i];
               if (!last_q) begin
                  state <= S_IDLE;
               end else if (double_q && !pass) begin
                  // Second pass hashes the 256-bit digest as a single pre-padded chunk.
                  for (int i = 0; i < 8; i++) begin
                     w[i]    <= hsum[i];
                     wk[i]   <= IV[i];
                     hreg[i] <= IV[i];
                  end
                  w[8] <= 32'h80000000;
                  for (int i = 9; i < 15; i++) w[i] <= '0;
                  w[15] <= 32'h00000100;
                  pass  <= 1'b1;
                  cnt   <= '0;
                  state <= S_ROUND;
               end else begin
                  state <= S_DONE;
`ifdef SHA256_TARGET_CMP_EN
                  hit <= (digest_next <= target);
`endif
               end
            end
            default: if (out_ready) begin
               state <= S_IDLE;
`ifdef SHA256_TARGET_CMP_EN
               hit <= 1'b0;
`endif
            end
         endcase
      end
   end

   assign in_ready   = (state == S_IDLE);
   assign out_valid  = (state == S_DONE);
   assign out_tag    = tag_q;
   assign final_hout = {hreg[0], hreg[1], hreg[2], hreg[3], hreg[4], hreg[5], hreg[6], hreg[7]};

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench for sha256_stream_core: message-level SHA-256 model, per-cycle digest compare, literal pins.
// Hit checks compile in when SHA256_TARGET_CMP_EN is defined.
module tb_sha256_stream_core;

   localparam logic [255:0] IV_VEC =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] LONG_BLK0 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] LONG_BLK1 = {480'h0, 32'h000001c0};

   localparam logic [255:0] D_ABC    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_ABC2   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
   localparam logic [255:0] D_LONG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, in_double = 1'b0;
   logic         in_ready, out_valid, out_ready = 1'b0;
   logic [511:0] datain = '0;
   logic [7:0]   in_tag = '0, out_tag;
   logic [255:0] final_hout;
`ifdef SHA256_TARGET_CMP_EN
   logic [255:0] target = '0;
   logic         hit;
`endif

   int checks = 0;
   int failures = 0;
   logic [255:0] exp_digest = '0;
   logic [7:0]   exp_tag = '0;
   logic [255:0] m_state = '0;
   logic [7:0]   m_tag = '0;
   logic         m_dbl = 1'b0;

   sha256_stream_core #(.CHUNKSIZE(512), .TAG_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .datain(datain),
      .in_first(in_first), .in_last(in_last), .in_double(in_double), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .final_hout(final_hout), .out_tag(out_tag)
`ifdef SHA256_TARGET_CMP_EN
      , .target(target), .hit(hit)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   // Textbook SHA-256 compression: full 64-word schedule, then 64 rounds on a state array.
   function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] res;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      for (int i = 0; i < 8; i++) v[i] = st[255-32*i -: 32];
      for (int i = 0; i < 64; i++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = st[255-32*i -: 32] + v[i];
      return res;
   endfunction

   // Digest and tag must match the model on every cycle the result is presented.
   always @(negedge clk) begin
      if (reset && out_valid) begin
         check("digest", final_hout, exp_digest);
         check("out_tag", 256'(out_tag), 256'(exp_tag));
      end
   end

   task automatic accept(input logic [511:0] blk, input logic first, input logic last,
                         input logic dbl, input logic [7:0] tag);
      int n;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("in_ready before accept", 256'(in_ready), 256'(1));
      in_valid = 1'b1; datain = blk; in_first = first; in_last = last; in_double = dbl; in_tag = tag;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_double = 1'b0;
   endtask

   task automatic send(input string name, input logic [511:0] blk, input logic first, input logic last,
                       input logic dbl, input logic [7:0] tag, input int lat);
      int n;
      bit busy_ok;
      if (first) begin
         m_state = IV_VEC;
         m_tag   = tag;
         m_dbl   = dbl;
      end
      m_state = compress(m_state, blk);
      if (last) begin
         exp_digest = m_dbl ? compress(IV_VEC, {m_state, 32'h80000000, 192'h0, 32'h00000100}) : m_state;
         exp_tag    = m_tag;
      end
      accept(blk, first, last, dbl, tag);
      n = 0;
      busy_ok = 1'b1;
      while (n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (last ? out_valid : in_ready) break;
         if (in_ready || out_valid) busy_ok = 1'b0;
      end
      check({name, " latency"}, 256'(n), 256'(lat));
      check({name, " in_ready low while busy"}, 256'(busy_ok), 256'(1));
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid drops after out_ready", 256'(out_valid), 256'(0));
      check("in_ready back after out_ready", 256'(in_ready), 256'(1));
   endtask

   initial begin
      #2;
      check("reset out_valid", 256'(out_valid), 256'(0));
      check("reset final_hout", final_hout, 256'h0);
      check("reset out_tag", 256'(out_tag), 256'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("in_ready after reset", 256'(in_ready), 256'(1));

      // Model pins against published vectors.
      check("model abc", compress(IV_VEC, ABC_BLK), D_ABC);
      check("model empty", compress(IV_VEC, EMPTY_BLK), D_EMPTY);

      send("abc single", ABC_BLK, 1'b1, 1'b1, 1'b0, 8'h11, 65);
      check("abc literal", final_hout, D_ABC);
      release_result();

      send("abc double", ABC_BLK, 1'b1, 1'b1, 1'b1, 8'h5A, 130);
      check("abc double literal", final_hout, D_ABC2);
      check("abc double tag literal", 256'(out_tag), 256'h5A);
      release_result();

      send("long chunk0", LONG_BLK0, 1'b1, 1'b0, 1'b0, 8'hC3, 65);
      send("long chunk1", LONG_BLK1, 1'b0, 1'b1, 1'b0, 8'h00, 65);
      check("long literal", final_hout, D_LONG);

      // Stall in DONE with a junk chunk offered; result must hold and nothing is accepted.
      in_valid = 1'b1;
      datain   = {16{32'hdeadbeef}};
      in_first = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall out_valid", 256'(out_valid), 256'(1));
         check("stall in_ready", 256'(in_ready), 256'(0));
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      release_result();

      send("empty", EMPTY_BLK, 1'b1, 1'b1, 1'b0, 8'h77, 65);
      check("empty literal", final_hout, D_EMPTY);
      release_result();

      // Reset during round 30 of a double hash.
      accept(ABC_BLK, 1'b1, 1'b1, 1'b1, 8'h99);
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("mid-round reset out_valid", 256'(out_valid), 256'(0));
      check("mid-round reset final_hout", final_hout, 256'h0);
      check("mid-round reset out_tag", 256'(out_tag), 256'(0));
      @(negedge clk);
      reset = 1'b1;
      send("abc after reset", ABC_BLK, 1'b1, 1'b1, 1'b0, 8'h22, 65);
      check("abc after reset literal", final_hout, D_ABC);
      release_result();

`ifdef SHA256_TARGET_CMP_EN
      target = D_ABC;
      send("hit eq", ABC_BLK, 1'b1, 1'b1, 1'b0, 8'h01, 65);
      check("hit target=digest", 256'(hit), 256'(1));
      release_result();
      check("hit cleared", 256'(hit), 256'(0));
      target = D_ABC - 256'd1;
      send("hit lt", ABC_BLK, 1'b1, 1'b1, 1'b0, 8'h02, 65);
      check("hit target=digest-1", 256'(hit), 256'(0));
      release_result();
      target = '1;
      send("hit ones", ABC_BLK, 1'b1, 1'b1, 1'b0, 8'h03, 65);
      check("hit target=ones", 256'(hit), 256'(1));
      release_result();
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
